// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory request/acknowledge bus for the memory stage
//
// Purpose: groups the data-memory handshake and bus signals.
// Signals:
//   dmem_req_o    memory request (driven by the memory stage)
//   dmem_we_o     1 for store
//   dmem_addr_o   word address, bits [1:0] = 0
//   dmem_be_o     byte enables
//   dmem_wdata_o  lane-placed store data
//   dmem_ack_i    access complete; dmem_rdata_i valid in the same cycle
//   dmem_rdata_i  read word
// Modports: master = memory stage, slave = data memory.
interface mem_stage_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_ack_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_ack_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory stage: EX/MEM register, data-memory FSM, lane logic
//
// Purpose: holds the EX/MEM pipeline register, runs an IDLE/REQ/DONE
// request/acknowledge FSM toward data memory for loads and stores, stalls the
// pipeline until the access completes, and performs store lane placement and
// load extraction/extension.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   valid_i                 EX holds a real instruction
//   inst_EX_i               instruction in EX (opcode, funct3 used)
//   alu_out_i               EX ALU result / effective address
//   store_data_i            forwarded rs2
//   pc_plus_four_i          PC+4 from EX
//   stall_o                 freezes IF/ID/EX and holds EX/MEM
//   alu_out_MEM_o           registered ALU result (EX forwarding)
//   pc_plus_four_MEM_o      registered PC+4 (EX forwarding)
//   inst_MEM_o              registered instruction
//   valid_MEM_o             instruction in MEM completes this cycle
//   load_data_o             extracted/extended load result (DONE only)
//   misalign_o              misaligned access trapped
//   dmem                    data-memory bus (mem_stage_if.master)
// Build option: MEM_MISALIGN_TRAP_EN - when defined, misaligned accesses are
// suppressed and flagged on misalign_o; otherwise they use the raw low bits.
module mem_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] inst_EX_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] pc_plus_four_i,
  output logic        stall_o,
  output logic [31:0] alu_out_MEM_o,
  output logic [31:0] pc_plus_four_MEM_o,
  output logic [31:0] inst_MEM_o,
  output logic        valid_MEM_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o,
  mem_stage_if.master dmem
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic        valid_q;
  logic [31:0] store_data_q;
  logic [31:0] rbuf_q;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        misaligned;
  logic        trap;
  logic        issue;
  logic [1:0]  size;
  logic [1:0]  a;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  assign a        = alu_out_MEM_o[1:0];
  assign size     = inst_MEM_o[13:12];
  assign sext     = ~inst_MEM_o[14];
  assign is_load  = valid_q && (inst_MEM_o[6:2] == 5'b00000);
  assign is_store = valid_q && (inst_MEM_o[6:2] == 5'b01000);
  assign is_mem   = is_load || is_store;

  // size 00 = byte, 01 = half, anything else is treated as a word
  assign misaligned = is_mem && (((size == 2'b01) && a[0]) ||
                                 (size[1] && (a != 2'b00)));

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = misaligned;
`else
  assign trap = 1'b0;
`endif

  assign issue = is_mem && !trap;

  // Depends only on state and the registered instruction, never on EX inputs.
  assign stall_o     = ((state == IDLE) && issue) || (state == REQ);
  assign valid_MEM_o = ((state == IDLE) && valid_q && !issue) || (state == DONE);
  assign misalign_o  = (state == IDLE) && trap;

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = store_data_q;
    if (is_store) begin
      case (size)
        2'b00: begin
          be_n    = 4'b0001 << a;
          wdata_n = {4{store_data_q[7:0]}};
        end
        2'b01: begin
          be_n    = 4'b0011 << {a[1], 1'b0};
          wdata_n = {2{store_data_q[15:0]}};
        end
        default: begin
          be_n    = 4'b1111;
          wdata_n = store_data_q;
        end
      endcase
    end
  end

  always_comb begin
    case (a)
      2'd0:    byte_sel = rbuf_q[7:0];
      2'd1:    byte_sel = rbuf_q[15:8];
      2'd2:    byte_sel = rbuf_q[23:16];
      default: byte_sel = rbuf_q[31:24];
    endcase
    half_sel    = a[1] ? rbuf_q[31:16] : rbuf_q[15:0];
    load_data_o = 32'h0;
    if ((state == DONE) && is_load) begin
      case (size)
        2'b00:   load_data_o = {{24{sext & byte_sel[7]}}, byte_sel};
        2'b01:   load_data_o = {{16{sext & half_sel[15]}}, half_sel};
        default: load_data_o = rbuf_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state              <= IDLE;
      valid_q            <= 1'b0;
      inst_MEM_o         <= 32'h0;
      alu_out_MEM_o      <= 32'h0;
      store_data_q       <= 32'h0;
      pc_plus_four_MEM_o <= 32'h0;
      rbuf_q             <= 32'h0;
      dmem.dmem_req_o    <= 1'b0;
      dmem.dmem_we_o     <= 1'b0;
      dmem.dmem_addr_o   <= 32'h0;
      dmem.dmem_be_o     <= 4'h0;
      dmem.dmem_wdata_o  <= 32'h0;
    end else begin
      if (!stall_o) begin
        valid_q            <= valid_i;
        inst_MEM_o         <= inst_EX_i;
        alu_out_MEM_o      <= alu_out_i;
        store_data_q       <= store_data_i;
        pc_plus_four_MEM_o <= pc_plus_four_i;
      end
      case (state)
        IDLE: begin
          if (issue) begin
            dmem.dmem_req_o   <= 1'b1;
            dmem.dmem_we_o    <= is_store;
            dmem.dmem_addr_o  <= {alu_out_MEM_o[31:2], 2'b00};
            dmem.dmem_be_o    <= be_n;
            dmem.dmem_wdata_o <= wdata_n;
            state             <= REQ;
          end
        end
        REQ: begin
          if (dmem.dmem_ack_i) begin
            rbuf_q          <= dmem.dmem_rdata_i;
            dmem.dmem_req_o <= 1'b0;
            state           <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i;
  logic [31:0] inst_ex, alu_in, sd_in, pc4_in;
  logic        stall_o, valid_MEM_o, misalign_o;
  logic [31:0] alu_out_MEM_o, pc_plus_four_MEM_o, inst_MEM_o, load_data_o;

  mem_stage_if bus();

  mem_stage dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .inst_EX_i(inst_ex),
    .alu_out_i(alu_in), .store_data_i(sd_in), .pc_plus_four_i(pc4_in),
    .stall_o(stall_o), .alu_out_MEM_o(alu_out_MEM_o),
    .pc_plus_four_MEM_o(pc_plus_four_MEM_o), .inst_MEM_o(inst_MEM_o),
    .valid_MEM_o(valid_MEM_o), .load_data_o(load_data_o),
    .misalign_o(misalign_o), .dmem(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] inst;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] pc4;
  } ent_t;

  ent_t exp_q[$];
  ent_t prog_q[$];
  int   dly_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  int tests = 0;
  int fails = 0;

  bit running = 0, stop_issue = 0, resp_en = 0, inited = 0, r_inited = 0;
  bit man_v = 0, man_ack = 1;
  logic [31:0] man_inst = 0, man_alu = 0;
  int issued = 0;
  int cnt = 0;
  int last_delay = 0;
  int wcnt = 0;
  bit in_req = 0;
  bit req_seen = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  int          lat_log[$];
  logic [31:0] ld_log[$], addr_log[$], wd_log[$];
  logic [3:0]  be_log[$];
  bit          req_log[$], mis_log[$];

  logic [6:0] alu_opcs [6] = '{7'b0110011, 7'b0010011, 7'b1100011,
                               7'b0110111, 7'b0010111, 7'b1101111};
  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic ent_t mk(bit v, logic [31:0] inst, logic [31:0] alu,
                              logic [31:0] sd, logic [31:0] pc4);
    ent_t e;
    e.v = v; e.inst = inst; e.alu = alu; e.sd = sd; e.pc4 = pc4;
    return e;
  endfunction

  function automatic int sz(logic [31:0] inst);
    case (inst[13:12])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_ld(ent_t e);
    return e.v && (e.inst[6:2] == 5'b00000);
  endfunction

  function automatic bit is_st(ent_t e);
    return e.v && (e.inst[6:2] == 5'b01000);
  endfunction

  function automatic bit trapped(ent_t e);
    bit mis;
    mis = (is_ld(e) || is_st(e)) && ((int'(e.alu[1:0]) % sz(e.inst)) != 0);
`ifdef MEM_MISALIGN_TRAP_EN
    return mis;
`else
    return mis & 1'b0;
`endif
  endfunction

  function automatic bit issues(ent_t e);
    return (is_ld(e) || is_st(e)) && !trapped(e);
  endfunction

  function automatic int lane_off(ent_t e);
    int s;
    s = sz(e.inst);
    return (int'(e.alu[1:0]) / s) * s;
  endfunction

  function automatic logic [3:0] exp_be(ent_t e);
    logic [31:0] t;
    if (!is_st(e)) return 4'hF;
    t = ((32'd1 << sz(e.inst)) - 32'd1) << lane_off(e);
    return t[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(ent_t e);
    if (!is_st(e)) return e.sd;
    case (sz(e.inst))
      1:       return (e.sd & 32'hFF) * 32'h01010101;
      2:       return (e.sd & 32'hFFFF) * 32'h00010001;
      default: return e.sd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(ent_t e, logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * lane_off(e));
    if (sz(e.inst) == 1) begin
      v = v & 32'hFF;
      if (!e.inst[14] && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz(e.inst) == 2) begin
      v = v & 32'hFFFF;
      if (!e.inst[14] && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 9);
    e = mk(1'b1, 32'h0, 32'h1000 * $urandom_range(1, 4) + $urandom_range(0, 15),
           $urandom, $urandom & 32'hFFFFFFFC);
    if (k == 0) begin
      e.v    = 1'b0;
      e.inst = {r[31:7], r[0] ? 7'b0100011 : 7'b0000011};
    end else if (k <= 3) begin
      e.inst = {r[31:7], alu_opcs[$urandom_range(0, 5)]};
      e.alu  = $urandom;
    end else if (k <= 6) begin
      e.inst = {r[31:15], ld_f3[$urandom_range(0, 4)], r[11:7], 7'b0000011};
    end else begin
      e.inst = {r[31:15], 3'($urandom_range(0, 2)), r[11:7], 7'b0100011};
    end
    return e;
  endfunction

  // Compare-and-drive process: checks MEM outputs against the model every
  // cycle and presents the next EX instruction whenever the pipe advances.
  always @(negedge clk) begin
    ent_t f, n;
    logic [31:0] wa, w;
    logic [3:0]  be;
    logic [31:0] wd;
    int          el;
    if (running) begin
      if (!inited) begin
        inited = 1;
        ref_mem[32'h2000] = 32'h0080FF00;
        ref_mem[32'h3000] = 32'h12345678;
        prog_q.push_back(mk(1, 32'h00208033, 32'h11223344, 32'h0, 32'h104));
        prog_q.push_back(mk(1, 32'h00000023, 32'h1003, 32'hA5, 32'h108));
        prog_q.push_back(mk(1, 32'h00000003, 32'h2002, 32'h0, 32'h10C));
        prog_q.push_back(mk(1, 32'h00004003, 32'h2002, 32'h0, 32'h110));
        prog_q.push_back(mk(1, 32'h00002023, 32'h4000, 32'hCAFEF00D, 32'h114));
        prog_q.push_back(mk(1, 32'h00002003, 32'h4000, 32'h0, 32'h118));
        prog_q.push_back(mk(1, 32'h00001003, 32'h3003, 32'h0, 32'h11C));
        prog_q.push_back(mk(1, 32'h00001023, 32'h3003, 32'hBEEF, 32'h120));
        exp_q.delete();
        exp_q.push_back(mk(0, 32'h0, 32'h0, 32'h0, 32'h0));
      end
      if (exp_q.size() == 0) begin
        chk("model_queue_nonempty", 32'd0, 32'd1);
      end else begin
        f = exp_q[0];
        chk("inst_MEM", inst_MEM_o, f.inst);
        chk("alu_out_MEM", alu_out_MEM_o, f.alu);
        chk("pc_plus_four_MEM", pc_plus_four_MEM_o, f.pc4);
        chk("misalign", misalign_o, trapped(f));
        if (cnt == 0) chk("req_in_first_cycle", bus.dmem_req_o, 1'b0);
        if (bus.dmem_req_o) begin
          chk("req_legal", issues(f), 1'b1);
          if (issues(f)) begin
            chk("dmem_addr", bus.dmem_addr_o, f.alu & 32'hFFFFFFFC);
            chk("dmem_we", bus.dmem_we_o, is_st(f));
            chk("dmem_be", bus.dmem_be_o, exp_be(f));
            if (is_st(f)) chk("dmem_wdata", bus.dmem_wdata_o, exp_wdata(f));
          end
          cap_addr = bus.dmem_addr_o; cap_be = bus.dmem_be_o;
          cap_wdata = bus.dmem_wdata_o; req_seen = 1;
        end
        if (!stall_o) begin
          wa = f.alu & 32'hFFFFFFFC;
          w  = ref_mem.exists(wa) ? ref_mem[wa] : 32'h0;
          el = issues(f) ? 3 + last_delay : 1;
          chk("valid_MEM", valid_MEM_o, f.v);
          chk("latency", cnt + 1, el);
          chk("load_data", load_data_o,
              (issues(f) && is_ld(f)) ? exp_load(f, w) : 32'h0);
          if (issues(f) && is_st(f)) begin
            be = exp_be(f); wd = exp_wdata(f);
            for (int i = 0; i < 4; i++)
              if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
            ref_mem[wa] = w;
          end
          if (f.v) begin
            lat_log.push_back(cnt + 1);
            ld_log.push_back(load_data_o);
            mis_log.push_back(misalign_o);
            req_log.push_back(req_seen);
            addr_log.push_back(cap_addr);
            be_log.push_back(cap_be);
            wd_log.push_back(cap_wdata);
          end
          void'(exp_q.pop_front());
          cnt = 0; req_seen = 0;
          if (stop_issue) n = mk(0, 32'h0, 32'h0, 32'h0, 32'h0);
          else if (prog_q.size() != 0) n = prog_q.pop_front();
          else n = rand_ent();
          valid_i = n.v; inst_ex = n.inst; alu_in = n.alu;
          sd_in = n.sd; pc4_in = n.pc4;
          exp_q.push_back(n);
          issued++;
        end else begin
          chk("valid_MEM_while_stalled", valid_MEM_o, 1'b0);
          chk("load_data_while_stalled", load_data_o, 32'h0);
          cnt++;
        end
      end
    end else begin
      valid_i = man_v; inst_ex = man_inst; alu_in = man_alu;
      sd_in = 32'h0; pc4_in = 32'h0;
    end
  end

  // Data-memory responder with random acknowledge delay and stray acks.
  always @(negedge clk) begin
    logic [31:0] w;
    if (!resp_en) begin
      bus.dmem_ack_i   = man_ack;
      bus.dmem_rdata_i = 32'h0;
      in_req = 0;
    end else begin
      if (!r_inited) begin
        r_inited = 1;
        slv_mem[32'h2000] = 32'h0080FF00;
        slv_mem[32'h3000] = 32'h12345678;
        dly_q = '{3, 0, 0, 0, 0, 0, 0};
      end
      if (bus.dmem_req_o) begin
        if (!in_req) begin
          in_req = 1; wcnt = 0;
          last_delay = (dly_q.size() != 0) ? dly_q.pop_front() : $urandom_range(0, 3);
        end
        if (wcnt == last_delay) begin
          w = slv_mem.exists(bus.dmem_addr_o) ? slv_mem[bus.dmem_addr_o] : 32'h0;
          bus.dmem_ack_i   = 1'b1;
          bus.dmem_rdata_i = w;
          if (bus.dmem_we_o) begin
            for (int i = 0; i < 4; i++)
              if (bus.dmem_be_o[i]) w[8*i +: 8] = bus.dmem_wdata_o[8*i +: 8];
            slv_mem[bus.dmem_addr_o] = w;
          end
          in_req = 0;
        end else begin
          bus.dmem_ack_i   = 1'b0;
          bus.dmem_rdata_i = $urandom;
          wcnt++;
        end
      end else begin
        in_req = 0;
        bus.dmem_ack_i   = ($urandom_range(0, 7) == 0);
        bus.dmem_rdata_i = $urandom;
      end
    end
  end

  initial begin
    // reset held with a stray ack
    repeat (3) @(negedge clk);
    chk("rst_req", bus.dmem_req_o, 1'b0);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_misalign", misalign_o, 1'b0);
    chk("rst_valid_MEM", valid_MEM_o, 1'b0);
    chk("rst_load_data", load_data_o, 32'h0);
    chk("rst_alu_MEM", alu_out_MEM_o, 32'h0);
    chk("rst_pc4_MEM", pc_plus_four_MEM_o, 32'h0);
    chk("rst_inst_MEM", inst_MEM_o, 32'h0);
    chk("rst_we", bus.dmem_we_o, 1'b0);
    chk("rst_be", bus.dmem_be_o, 4'h0);
    man_ack = 0;
    @(posedge clk); #2;
    rst = 0; resp_en = 1; running = 1;

    for (int c = 0; c < 500 && ld_log.size() < 8; c++) @(negedge clk);
    if (ld_log.size() < 8) begin
      chk("directed_timeout", 32'd0, 32'd1);
    end else begin
      chk("lit_add_latency", lat_log[0], 1);
      chk("lit_sb_latency", lat_log[1], 6);
      chk("lit_sb_addr", addr_log[1], 32'h1000);
      chk("lit_sb_be", be_log[1], 4'b1000);
      chk("lit_sb_wdata", wd_log[1], 32'hA5A5A5A5);
      chk("lit_lb_data", ld_log[2], 32'hFFFFFF80);
      chk("lit_lb_latency", lat_log[2], 3);
      chk("lit_lbu_data", ld_log[3], 32'h00000080);
      chk("lit_sw_lw_cycles", lat_log[4] + lat_log[5], 6);
      chk("lit_lw_data", ld_log[5], 32'hCAFEF00D);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("lit_lh_trap_data", ld_log[6], 32'h0);
      chk("lit_lh_trap_flag", mis_log[6], 1'b1);
      chk("lit_lh_trap_latency", lat_log[6], 1);
      chk("lit_sh_trap_noreq", req_log[7], 1'b0);
`else
      chk("lit_lh_data", ld_log[6], 32'h00001234);
      chk("lit_sh_be", be_log[7], 4'b1100);
      chk("lit_sh_wdata", wd_log[7], 32'hBEEFBEEF);
`endif
    end

    for (int c = 0; c < 20000 && issued < 400; c++) @(negedge clk);
    if (issued < 400) chk("random_timeout", issued, 400);
    stop_issue = 1;
    repeat (40) @(negedge clk);
    @(posedge clk); #2;
    running = 0; resp_en = 0; man_ack = 0; man_v = 0;
    repeat (3) @(negedge clk);

    // reset asserted while a load is waiting in REQ
    @(posedge clk); #2;
    man_v = 1; man_inst = 32'h00002003; man_alu = 32'h4000;
    @(posedge clk); #2;
    man_v = 0;
    @(posedge clk); #2;
    chk("req_before_reset", bus.dmem_req_o, 1'b1);
    rst = 1;
    #1;
    chk("req_drops_async", bus.dmem_req_o, 1'b0);
    chk("stall_in_reset", stall_o, 1'b0);
    man_ack = 1;
    @(posedge clk); #2;
    rst = 0;
    @(posedge clk); #2;
    chk("late_ack_req", bus.dmem_req_o, 1'b0);
    chk("late_ack_valid", valid_MEM_o, 1'b0);
    chk("late_ack_stall", stall_o, 1'b0);
    man_ack = 0;
    @(posedge clk); #2;
    chk("after_late_ack_req", bus.dmem_req_o, 1'b0);
    chk("after_late_ack_valid", valid_MEM_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
